axi_b_buffer_ft: RTL and testbench

Parametrised AXI write-response (B) channel buffer with self-contained storage, optional fall-through when empty, occupancy reporting and a saturating error-response counter. Sits between an AXI slave's B output and the upstream master port in the axi_slice family and decouples the two handshakes. It replaces the plain FIFO-wrapper B buffer wherever latency-sensitive paths or response-error monitoring are needed.

---
 rtl/axi_slice_pkg.sv | 21 ++
 rtl/axi_buffer_core.sv | 106 ++++++++++
 rtl/axi_b_buffer_ft.sv | 96 +++++++++
 tb/tb_axi_b_buffer_ft.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slice_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_slice_pkg
// Description : Shared AXI slice definitions: BRESP encodings and a helper
//               that classifies a response as an error (SLVERR / DECERR).
// Revision    : 1.0 - initial release
// ============================================================================
package axi_slice_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Both error encodings have bit 1 set; compare explicitly for clarity.
    function automatic logic is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_buffer_core.sv
`default_nettype none
// ============================================================================
// Module      : axi_buffer_core
// Description : Generic valid/ready buffer with register-array storage,
//               wrapping pointers, occupancy count and optional fall-through
//               when empty. Payload-agnostic so every AXI channel can reuse it.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_buffer_core #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 8,
    parameter int FALL_THROUGH = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [DATA_WIDTH-1:0]       in_data_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [DATA_WIDTH-1:0]       out_data_o,
    output logic [$clog2(DEPTH):0]      usage_o,
    output logic                        full_o,
    output logic                        empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Storage is intentionally not reset; the count alone qualifies it.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic w_bypass;
    logic w_push;
    logic w_pop;
    logic w_write_en;
    logic w_read_en;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign usage_o    = count_q;
    // Ready comes from registered state only, so it never depends on out_ready_i.
    assign in_ready_o = !full_o;

    // Fall-through presents the incoming beat directly while nothing is stored.
    generate
        if (FALL_THROUGH != 0) begin : g_fall_through
            assign w_bypass = empty_o & in_valid_i;
        end else begin : g_no_fall_through
            assign w_bypass = 1'b0;
        end
    endgenerate

    assign out_valid_o = !empty_o | w_bypass;
    assign out_data_o  = w_bypass ? in_data_i : mem_q[rd_ptr_q];

    assign w_push     = in_valid_i & in_ready_o;
    assign w_pop      = out_valid_o & out_ready_i;
    // A bypassed beat taken in the same cycle never touches storage.
    assign w_write_en = w_push & !(w_bypass & out_ready_i);
    assign w_read_en  = w_pop & !empty_o;

    // Next-state for pointers and occupancy count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_write_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_read_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({w_write_en, w_read_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset discards all stored beats at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry write at the tail pointer.
    always_ff @(posedge clk_i) begin
        if (w_write_en) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_b_buffer_ft.sv
`default_nettype none
// ============================================================================
// Module      : axi_b_buffer_ft
// Description : AXI write-response (B) channel buffer with optional
//               fall-through, occupancy reporting and a saturating counter
//               of SLVERR/DECERR responses delivered upstream.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_b_buffer_ft
    import axi_slice_pkg::*;
#(
    parameter int ID_WIDTH      = 4,
    parameter int USER_WIDTH    = 6,
    parameter int BUFFER_DEPTH  = 8,
    parameter int FALL_THROUGH  = 0,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          test_en_i,
    input  logic                          slave_valid_i,
    output logic                          slave_ready_o,
    input  logic [1:0]                    slave_resp_i,
    input  logic [ID_WIDTH-1:0]           slave_id_i,
    input  logic [USER_WIDTH-1:0]         slave_user_i,
    output logic                          master_valid_o,
    input  logic                          master_ready_i,
    output logic [1:0]                    master_resp_o,
    output logic [ID_WIDTH-1:0]           master_id_o,
    output logic [USER_WIDTH-1:0]         master_user_o,
    output logic [$clog2(BUFFER_DEPTH):0] usage_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [ERR_CNT_WIDTH-1:0]      err_cnt_o,
    input  logic                          err_clr_i
);

    localparam int DATA_W = 2 + ID_WIDTH + USER_WIDTH;

    logic [DATA_W-1:0]        w_in_data;
    logic [DATA_W-1:0]        w_out_data;
    logic                     w_err_pop;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                     w_unused_test_en;

    // Test mode has no functional effect here.
    assign w_unused_test_en = test_en_i;

    assign w_in_data = {slave_id_i, slave_user_i, slave_resp_i};

    axi_buffer_core #(
        .DATA_WIDTH   (DATA_W),
        .DEPTH        (BUFFER_DEPTH),
        .FALL_THROUGH (FALL_THROUGH)
    ) u_core (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (slave_valid_i),
        .in_ready_o  (slave_ready_o),
        .in_data_i   (w_in_data),
        .out_valid_o (master_valid_o),
        .out_ready_i (master_ready_i),
        .out_data_o  (w_out_data),
        .usage_o     (usage_o),
        .full_o      (full_o),
        .empty_o     (empty_o)
    );

    assign {master_id_o, master_user_o, master_resp_o} = w_out_data;

    // Only responses actually delivered upstream are counted.
    assign w_err_pop = master_valid_o & master_ready_i & is_err(master_resp_o);

    // Saturating error count; a clear still counts an error popped that cycle.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr_i) begin
            err_cnt_d = w_err_pop ? ERR_CNT_WIDTH'(1) : '0;
        end else if (w_err_pop && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
        end
    end

    // Error counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_b_buffer_ft.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_b_buffer_ft
// Description : Self-checking bench for axi_b_buffer_ft. Instance A uses the
//               default configuration (depth 8, no fall-through); instance B
//               uses depth 4, fall-through and a 2-bit error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_b_buffer_ft;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic test_en = 1'b0;

    always #5 clk = ~clk;

    // Instance A signals
    logic       a_sv = 1'b0, a_sr, a_mv, a_mr = 1'b0;
    logic [1:0] a_resp = 2'd0, a_mresp;
    logic [3:0] a_id = 4'd0, a_mid;
    logic [5:0] a_user = 6'd0, a_muser;
    logic [3:0] a_usage;
    logic       a_full, a_empty, a_clr = 1'b0;
    logic [7:0] a_err;

    // Instance B signals
    logic       b_sv = 1'b0, b_sr, b_mv, b_mr = 1'b0;
    logic [1:0] b_resp = 2'd0, b_mresp;
    logic [3:0] b_id = 4'd0, b_mid;
    logic [5:0] b_user = 6'd0, b_muser;
    logic [2:0] b_usage;
    logic       b_full, b_empty, b_clr = 1'b0;
    logic [1:0] b_err;

    axi_b_buffer_ft dut_a (
        .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en),
        .slave_valid_i(a_sv), .slave_ready_o(a_sr), .slave_resp_i(a_resp),
        .slave_id_i(a_id), .slave_user_i(a_user),
        .master_valid_o(a_mv), .master_ready_i(a_mr), .master_resp_o(a_mresp),
        .master_id_o(a_mid), .master_user_o(a_muser),
        .usage_o(a_usage), .full_o(a_full), .empty_o(a_empty),
        .err_cnt_o(a_err), .err_clr_i(a_clr)
    );

    axi_b_buffer_ft #(
        .BUFFER_DEPTH(4), .FALL_THROUGH(1), .ERR_CNT_WIDTH(2)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en),
        .slave_valid_i(b_sv), .slave_ready_o(b_sr), .slave_resp_i(b_resp),
        .slave_id_i(b_id), .slave_user_i(b_user),
        .master_valid_o(b_mv), .master_ready_i(b_mr), .master_resp_o(b_mresp),
        .master_id_o(b_mid), .master_user_o(b_muser),
        .usage_o(b_usage), .full_o(b_full), .empty_o(b_empty),
        .err_cnt_o(b_err), .err_clr_i(b_clr)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic       sv;
        logic [1:0] resp;
        logic [3:0] id;
        logic       mr;
        logic       clr;
        logic       exp_mv;
        logic [3:0] exp_id;
        logic [1:0] exp_resp;
        logic [2:0] exp_usage;
        logic [1:0] exp_err;
    } vec_t;

    function automatic vec_t mk(input logic sv, input logic [1:0] resp, input logic [3:0] id,
                                input logic mr, input logic clr, input logic exp_mv,
                                input logic [3:0] exp_id, input logic [1:0] exp_resp,
                                input logic [2:0] exp_usage, input logic [1:0] exp_err);
        vec_t v;
        v.sv = sv; v.resp = resp; v.id = id; v.mr = mr; v.clr = clr;
        v.exp_mv = exp_mv; v.exp_id = exp_id; v.exp_resp = exp_resp;
        v.exp_usage = exp_usage; v.exp_err = exp_err;
        return v;
    endfunction

    vec_t vecs [11];

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int in_seq;
        int out_seq;
        int max_usage;
        logic pend;

        // Fall-through / error-counter vectors for instance B (depth 4, 2-bit counter).
        //             sv    resp  id     mr    clr   mv    id     resp  usage err
        vecs[0]  = mk(1'b1, 2'd2, 4'd1, 1'b1, 1'b0, 1'b1, 4'd1, 2'd2, 3'd0, 2'd1);
        vecs[1]  = mk(1'b1, 2'd3, 4'd2, 1'b1, 1'b0, 1'b1, 4'd2, 2'd3, 3'd0, 2'd2);
        vecs[2]  = mk(1'b1, 2'd0, 4'd3, 1'b0, 1'b0, 1'b1, 4'd3, 2'd0, 3'd1, 2'd2);
        vecs[3]  = mk(1'b1, 2'd2, 4'd4, 1'b1, 1'b0, 1'b1, 4'd3, 2'd0, 3'd1, 2'd2);
        vecs[4]  = mk(1'b0, 2'd0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd4, 2'd2, 3'd0, 2'd3);
        vecs[5]  = mk(1'b1, 2'd3, 4'd5, 1'b1, 1'b0, 1'b1, 4'd5, 2'd3, 3'd0, 2'd3);
        vecs[6]  = mk(1'b1, 2'd2, 4'd6, 1'b1, 1'b1, 1'b1, 4'd6, 2'd2, 3'd0, 2'd1);
        vecs[7]  = mk(1'b1, 2'd2, 4'd7, 1'b0, 1'b1, 1'b1, 4'd7, 2'd2, 3'd1, 2'd0);
        vecs[8]  = mk(1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd7, 2'd2, 3'd1, 2'd0);
        vecs[9]  = mk(1'b0, 2'd0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd7, 2'd2, 3'd0, 2'd1);
        vecs[10] = mk(1'b0, 2'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 3'd0, 2'd1);

        // ---- reset values ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_a_ready", 32'(a_sr), 32'd1);
        check("rst_a_mvalid", 32'(a_mv), 32'd0);
        check("rst_a_empty", 32'(a_empty), 32'd1);
        check("rst_a_full", 32'(a_full), 32'd0);
        check("rst_a_usage", 32'(a_usage), 32'd0);
        check("rst_a_err", 32'(a_err), 32'd0);
        check("rst_b_mvalid", 32'(b_mv), 32'd0);
        rst_n = 1'b1;

        // ---- fill instance A with ids 0..7, master stalled ----
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a_sv = 1'b1; a_id = i[3:0]; a_resp = i[1:0]; a_mr = 1'b0;
            @(posedge clk); #1;
            check($sformatf("fill%0d_usage", i), 32'(a_usage), 32'(i + 1));
            if (i == 0) begin
                check("fill0_mvalid", 32'(a_mv), 32'd1);
                check("fill0_head_id", 32'(a_mid), 32'd0);
            end
        end
        check("full_flag", 32'(a_full), 32'd1);
        check("full_ready", 32'(a_sr), 32'd0);
        check("full_empty", 32'(a_empty), 32'd0);
        // ninth beat is stalled
        @(negedge clk);
        a_sv = 1'b1; a_id = 4'd8; a_resp = 2'd0;
        @(posedge clk); #1;
        check("ninth_stalled_usage", 32'(a_usage), 32'd8);

        // ---- drain in order ----
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a_mr = 1'b1;
            if (i == 0) begin
                #1;
                check("full_pop_ready", 32'(a_sr), 32'd0);
            end else begin
                a_sv = 1'b0;
                #1;
            end
            check($sformatf("drain%0d_mvalid", i), 32'(a_mv), 32'd1);
            check($sformatf("drain%0d_id", i), 32'(a_mid), 32'(i));
            check($sformatf("drain%0d_resp", i), 32'(a_mresp), 32'(i % 4));
            @(posedge clk); #1;
            check($sformatf("drain%0d_usage", i), 32'(a_usage), 32'(7 - i));
        end
        check("drain_empty", 32'(a_empty), 32'd1);
        check("drain_mvalid_off", 32'(a_mv), 32'd0);
        check("drain_err_cnt", 32'(a_err), 32'd4);
        @(negedge clk);
        a_mr = 1'b0;

        // ---- table-driven vectors on instance B ----
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            b_sv = vecs[i].sv; b_resp = vecs[i].resp; b_id = vecs[i].id;
            b_user = 6'd0; b_mr = vecs[i].mr; b_clr = vecs[i].clr;
            #1;
            check($sformatf("vec%0d_mvalid", i), 32'(b_mv), 32'(vecs[i].exp_mv));
            check($sformatf("vec%0d_sready", i), 32'(b_sr), 32'd1);
            if (vecs[i].exp_mv) begin
                check($sformatf("vec%0d_id", i), 32'(b_mid), 32'(vecs[i].exp_id));
                check($sformatf("vec%0d_resp", i), 32'(b_mresp), 32'(vecs[i].exp_resp));
            end
            @(posedge clk); #1;
            check($sformatf("vec%0d_usage", i), 32'(b_usage), 32'(vecs[i].exp_usage));
            check($sformatf("vec%0d_err", i), 32'(b_err), 32'(vecs[i].exp_err));
        end
        @(negedge clk);
        b_sv = 1'b0; b_mr = 1'b0; b_clr = 1'b0; b_resp = 2'd0;

        // ---- random-ready stream on instance B, 100 beats ----
        in_seq = 0; out_seq = 0; max_usage = 0; pend = 1'b0;
        for (int c = 0; c < 3000 && out_seq < 100; c++) begin
            @(negedge clk);
            if (!pend) begin
                b_sv = (in_seq < 100) && ($urandom_range(3) != 0);
                {b_id, b_user} = in_seq[9:0];
            end
            b_mr = ($urandom_range(1) == 1);
            #1;
            if (b_mv && b_mr) begin
                check("stream_data", 32'({b_mid, b_muser}), 32'(out_seq));
                out_seq++;
            end
            if (b_sv && b_sr) begin
                in_seq++;
                pend = 1'b0;
            end else begin
                pend = b_sv;
            end
            if (int'(b_usage) > max_usage) max_usage = int'(b_usage);
        end
        check("stream_done", 32'(out_seq), 32'd100);
        check("stream_usage_bound", 32'(max_usage <= 4), 32'd1);
        @(negedge clk);
        b_sv = 1'b0; b_mr = 1'b0;

        // ---- asynchronous reset with 5 entries stored in A ----
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_sv = 1'b1; a_id = i[3:0]; a_resp = 2'd2; a_mr = 1'b0;
        end
        @(negedge clk);
        a_sv = 1'b0;
        #1;
        check("pre_reset_usage", 32'(a_usage), 32'd5);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_mvalid", 32'(a_mv), 32'd0);
        check("async_rst_usage", 32'(a_usage), 32'd0);
        check("async_rst_empty", 32'(a_empty), 32'd1);
        check("async_rst_full", 32'(a_full), 32'd0);
        check("async_rst_ready", 32'(a_sr), 32'd1);
        check("async_rst_err", 32'(a_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_no_beat", 32'(a_mv), 32'd0);
        @(negedge clk);
        a_sv = 1'b1; a_id = 4'hA; a_resp = 2'd0;
        @(posedge clk); #1;
        @(negedge clk);
        a_sv = 1'b0; a_mr = 1'b1;
        #1;
        check("post_rst_mvalid", 32'(a_mv), 32'd1);
        check("post_rst_id", 32'(a_mid), 32'hA);
        check("post_rst_usage", 32'(a_usage), 32'd1);
        @(posedge clk); #1;
        check("post_rst_sole_usage", 32'(a_usage), 32'd0);
        check("post_rst_sole_mvalid", 32'(a_mv), 32'd0);
        @(negedge clk);
        a_mr = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
